// File: rtl/rx_bit_timer.sv
// Receive-side bit/byte timer: recovers bit timing from D+ edges, strobes mid-bit,
// skips stuffed bits, counts bits and bytes and flags oversized packets and lost transitions.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       stuff_bit,
  input  logic       clear,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_count,
  output logic [6:0] byte_count,
  output logic       overflow,
  output logic       edge_timeout
);

  localparam int            PW        = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [6:0]    MAX_CNT   = 7'(MAX_BYTES);

  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    run_q, run_d;
  logic          rcving_q;
  logic          byte_rx_q, byte_rx_d;
  logic          ovf_q, ovf_d;
  logic          tout_q, tout_d;

  logic pkt_start;
  logic data_bit;

  // The strobe decodes the registered phase, so an edge in the same cycle cannot suppress it.
  assign shift_enable = rcving && !clear && (phase_q == PH_SAMPLE);
  assign pkt_start    = rcving && !rcving_q;
  assign data_bit     = shift_enable && !stuff_bit;

  // Phase recovery: an edge marks phase 0, so the following cycle is phase 1.
  always_comb begin
    phase_d = phase_q;
    if (clear || !rcving) begin
      phase_d = '0;
    end else if (d_edge) begin
      phase_d = PW'(1);
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  // Bit, byte and run counters plus sticky flags; counts hold while idle so byte_count survives EOP.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    run_d      = run_q;
    byte_rx_d  = 1'b0;
    ovf_d      = ovf_q;
    tout_d     = tout_q;
    if (clear) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 7'd0;
      run_d      = 4'd0;
      ovf_d      = 1'b0;
      tout_d     = 1'b0;
    end else if (!rcving) begin
      bit_cnt_d = bit_cnt_q;
    end else if (pkt_start) begin
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 7'd0;
      run_d      = 4'd0;
      ovf_d      = 1'b0;
      tout_d     = 1'b0;
    end else begin
      if (d_edge) begin
        run_d = 4'd0;
      end else if (shift_enable && (run_q != 4'd8)) begin
        run_d = run_q + 4'd1;
      end else begin
        run_d = run_q;
      end
      if (run_d == 4'd8) begin
        tout_d = 1'b1;
      end else begin
        tout_d = tout_q;
      end
      if (data_bit) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
      if (data_bit && (bit_cnt_q == 3'd7)) begin
        byte_rx_d = 1'b1;
        if (byte_cnt_q < MAX_CNT) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        byte_rx_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q    <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 7'd0;
      run_q      <= 4'd0;
      rcving_q   <= 1'b0;
      byte_rx_q  <= 1'b0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      run_q      <= run_d;
      rcving_q   <= rcving;
      byte_rx_q  <= byte_rx_d;
      ovf_q      <= ovf_d;
      tout_q     <= tout_d;
    end
  end

  assign byte_received = byte_rx_q;
  assign bit_count     = bit_cnt_q;
  assign byte_count    = byte_cnt_q;
  assign overflow      = ovf_q;
  assign edge_timeout  = tout_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios plus randomized jitter and stuffing,
// compared cycle by cycle against an arithmetic reference model.
module tb_rx_bit_timer;
  localparam int CPB  = 8;
  localparam int SP   = 3;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rcving = 1'b0;
  logic       d_edge = 1'b0;
  logic       stuff_bit = 1'b0;
  logic       clear = 1'b0;
  logic       shift_enable;
  logic       byte_received;
  logic [2:0] bit_count;
  logic [6:0] byte_count;
  logic       overflow;
  logic       edge_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: bit phase measured from an anchor cycle, totals as plain integers.
  int  cyc = 0;
  int  m_anchor = 0;
  int  m_bits = 0;
  int  m_run = 0;
  bit  m_to = 1'b0;
  bit  m_br = 1'b0;
  bit  m_prev = 1'b0;
  bit  m_se = 1'b0;
  logic obs_se;
  logic [13:0] obs_v, exp_v;

  rx_bit_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .n_rst(n_rst), .rcving(rcving), .d_edge(d_edge), .stuff_bit(stuff_bit),
    .clear(clear), .shift_enable(shift_enable), .byte_received(byte_received),
    .bit_count(bit_count), .byte_count(byte_count), .overflow(overflow),
    .edge_timeout(edge_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bits = 0; m_run = 0; m_to = 1'b0; m_br = 1'b0; m_prev = 1'b0; m_anchor = cyc;
  endtask

  // One clock: drive inputs, capture the strobe before the edge, advance the model, capture outputs.
  task automatic cycle(input bit rcv, input bit edg, input bit stf, input bit clr);
    int nbytes;
    @(negedge clk);
    rcving = rcv; d_edge = edg; stuff_bit = stf; clear = clr;
    #1;
    m_se = rcv && !clr && (((cyc - m_anchor) % CPB) == SP);
    obs_se = shift_enable;
    @(posedge clk);
    m_br = 1'b0;
    if (clr) begin
      m_bits = 0; m_run = 0; m_to = 1'b0; m_anchor = cyc + 1;
    end else if (!rcv) begin
      m_anchor = cyc + 1;
    end else begin
      if (!m_prev) begin m_bits = 0; m_run = 0; m_to = 1'b0; end
      if (edg) begin
        m_anchor = cyc; m_run = 0;
      end else if (m_se && m_run < 8) begin
        m_run = m_run + 1;
      end
      if (m_se && !stf) begin
        m_bits = m_bits + 1;
        m_br = ((m_bits % 8) == 0);
      end
      if (m_run == 8) m_to = 1'b1;
    end
    m_prev = rcv;
    cyc = cyc + 1;
    #1;
    nbytes = m_bits / 8;
    obs_v = {obs_se, byte_received, bit_count, byte_count, overflow, edge_timeout};
    exp_v = {m_se, m_br, 3'(m_bits % 8), 7'((nbytes > MAXB) ? MAXB : nbytes),
             (nbytes > MAXB), m_to};
  endtask

  task automatic test_reset();
    logic [12:0] regs;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    regs = {byte_received, bit_count, byte_count, overflow, edge_timeout};
    checks++;
    if (regs !== 13'd0 || shift_enable !== 1'b0) begin
      errors++; $display("FAIL reset_state got %b se=%b expected all zero", regs, shift_enable);
    end
    @(posedge clk); #2; n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_ideal();
    int strobes = 0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, (i % 8) == 0, 1'b0, 1'b0);
      if (obs_se === 1'b1) strobes++;
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL ideal_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      checks++;
      if (obs_se !== ((i % 8) == 3)) begin
        errors++; $display("FAIL ideal_strobe i=%0d got %b expected %b", i, obs_se, (i % 8) == 3);
      end
    end
    checks++;
    if (strobes != 8 || byte_count !== 7'd1) begin
      errors++; $display("FAIL ideal_byte strobes=%0d byte_count=%0d expected 8 and 1", strobes, byte_count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL idle_hold i=%0d got %b expected %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_drift();
    int next_edge;
    int edges = 0;
    int strobes = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i == 0) || (i == 5), 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL drift_phase5 i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      if (i == 8 || i == 11) begin
        checks++;
        if (obs_se !== (i == 8)) begin
          errors++; $display("FAIL drift_resync i=%0d got %b expected %b", i, obs_se, i == 8);
        end
      end
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    next_edge = 0;
    for (int i = 0; i < 260; i++) begin
      bit edg;
      edg = (i == next_edge) && (i < 240);
      if (edg) begin
        edges++;
        next_edge = i + int'($urandom_range(6, 10));
      end
      cycle(1'b1, edg, $urandom_range(0, 7) == 0, 1'b0);
      if (obs_se === 1'b1 && i < 244) strobes++;
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL drift_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
    end
    checks++;
    if (strobes != edges) begin
      errors++; $display("FAIL drift_one_per_bit strobes=%0d expected %0d", strobes, edges);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stuffing();
    for (int i = 0; i < 72; i++) begin
      cycle(1'b1, (i % 8) == 0, i == 35, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL stuff_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      if (i == 35 || i == 59 || i == 67) begin
        checks++;
        if (byte_received !== (i == 67) || bit_count !== ((i == 35) ? 3'd4 : (i == 59) ? 3'd7 : 3'd0)) begin
          errors++; $display("FAIL stuff_skip i=%0d got br=%b bc=%0d", i, byte_received, bit_count);
        end
      end
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 320; i++) begin
      cycle(1'b1, (i % 8) == 0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL ovf_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      if (i == 251 || i == 315) begin
        checks++;
        if (byte_count !== 7'd4 || overflow !== (i == 315) || byte_received !== 1'b1) begin
          errors++; $display("FAIL ovf_sat i=%0d got cnt=%0d ovf=%b br=%b", i, byte_count, overflow, byte_received);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL ovf_hold i=%0d got %b expected %b", i, obs_v, exp_v);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (byte_count !== 7'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_restart got cnt=%0d ovf=%b expected 0 0", byte_count, overflow);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, i == 0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL tout_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      if (i == 58 || i == 59) begin
        checks++;
        if (edge_timeout !== (i == 59)) begin
          errors++; $display("FAIL tout_8th i=%0d got %b expected %b", i, edge_timeout, i == 59);
        end
      end
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 52; i++) begin
      cycle(1'b1, i == 0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL tout7_model i=%0d got %b expected %b", i, obs_v, exp_v);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (edge_timeout !== 1'b0) begin
      errors++; $display("FAIL tout_7strobes got %b expected 0", edge_timeout);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_reset();
    logic [12:0] regs;
    for (int i = 0; i < 36; i++) cycle(1'b1, (i % 8) == 0, 1'b0, 1'b0);
    checks++;
    if (bit_count !== 3'd5) begin
      errors++; $display("FAIL clr_setup got bit_count=%0d expected 5", bit_count);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_v !== 14'd0 || obs_v !== exp_v) begin
      errors++; $display("FAIL clear_zero got %b expected %b", obs_v, exp_v);
    end
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, (i % 8) == 0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL clr_after i=%0d got %b expected %b", i, obs_v, exp_v);
      end
    end
    checks++;
    if (byte_count !== 7'd1 || bit_count !== 3'd0) begin
      errors++; $display("FAIL clr_recount got cnt=%0d bc=%0d expected 1 0", byte_count, bit_count);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) cycle(1'b1, (i % 8) == 0, 1'b0, 1'b0);
    @(negedge clk); #2;
    n_rst = 1'b0;
    #1;
    regs = {byte_received, bit_count, byte_count, overflow, edge_timeout};
    checks++;
    if (regs !== 13'd0 || shift_enable !== 1'b0) begin
      errors++; $display("FAIL rst_mid got %b se=%b expected all zero", regs, shift_enable);
    end
    repeat (2) @(posedge clk);
    #2; n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL rst_after i=%0d got %b expected %b", i, obs_v, exp_v);
      end
      if (i <= 3) begin
        checks++;
        if (obs_se !== (i == 3)) begin
          errors++; $display("FAIL rst_first_strobe i=%0d got %b expected %b", i, obs_se, i == 3);
        end
      end
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_drift();
    test_stuffing();
    test_overflow();
    test_timeout();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
